// File: rtl/spi_byte_rx.sv
// Mode-0 SPI byte receiver: synchronizes the raw SPI clock/data into clk_in, shifts bits MSB first,
// strobes each completed byte and discards partial bytes that go idle for TIMEOUT_CYCLES.
module spi_byte_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       chip_data_raw,
  input  logic       chip_clk_raw,
  output logic [7:0] data_out,
  output logic       data_valid_out,
  output logic       frame_error_out,
  output logic [2:0] bit_count_out
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_hist;
  logic                   spi_edge, spi_bit;

  state_t      state, state_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [15:0] idle_cnt, idle_cnt_nx;
  logic [7:0]  shreg, shreg_nx, data_nx;
  logic        valid_nx, ferr_nx;

  // Equal-depth chains keep data aligned with the clock it was launched against.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_hist  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], chip_clk_raw};
      data_sync <= {data_sync[SYNC_STAGES-2:0], chip_data_raw};
      clk_hist  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign spi_edge = clk_sync[SYNC_STAGES-1] & ~clk_hist;
  assign spi_bit  = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      idle_cnt        <= '0;
      shreg           <= '0;
      data_out        <= '0;
      data_valid_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      state           <= state_nx;
      bit_cnt         <= bit_cnt_nx;
      idle_cnt        <= idle_cnt_nx;
      shreg           <= shreg_nx;
      data_out        <= data_nx;
      data_valid_out  <= valid_nx;
      frame_error_out <= ferr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    idle_cnt_nx = idle_cnt;
    shreg_nx    = shreg;
    data_nx     = data_out;
    valid_nx    = 1'b0;
    ferr_nx     = 1'b0;
    case (state)
      IDLE: begin
        idle_cnt_nx = '0;
        if (spi_edge) begin
          state_nx   = SHIFT;
          bit_cnt_nx = 3'd1;
          shreg_nx   = {shreg[6:0], spi_bit};
        end
      end
      SHIFT: begin
        // An edge on the timeout cycle wins: the bit is kept and the counter restarts.
        if (spi_edge) begin
          idle_cnt_nx = '0;
          shreg_nx    = {shreg[6:0], spi_bit};
          if (bit_cnt == 3'd7) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            data_nx    = {shreg[6:0], spi_bit};
            valid_nx   = 1'b1;
            shreg_nx   = '0;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end else if (idle_cnt == TIMEOUT_LAST) begin
          state_nx    = IDLE;
          bit_cnt_nx  = '0;
          idle_cnt_nx = '0;
          shreg_nx    = '0;
          ferr_nx     = 1'b1;
        end else begin
          idle_cnt_nx = idle_cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bit_count_out = bit_cnt;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Drives two receivers (default timeout and a 4-cycle timeout) from one SPI stream and
// scoreboards every strobe, data_out and bit_count_out against an event-timeline model.
module tb_spi_byte_rx;
  localparam int S  = 2;
  localparam int T0 = 1000;
  localparam int T1 = 4;

  logic clk_in = 1'b0, rst_n_in = 1'b0, spi_clk = 1'b0, spi_dat = 1'b0;
  logic [1:0][7:0] dout;
  logic [1:0]      dv, fe;
  logic [1:0][2:0] bc;

  spi_byte_rx #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T0)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .chip_data_raw(spi_dat), .chip_clk_raw(spi_clk),
    .data_out(dout[0]), .data_valid_out(dv[0]), .frame_error_out(fe[0]), .bit_count_out(bc[0]));

  spi_byte_rx #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T1)) dut_t4 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .chip_data_raw(spi_dat), .chip_clk_raw(spi_clk),
    .data_out(dout[1]), .data_valid_out(dv[1]), .frame_error_out(fe[1]), .bit_count_out(bc[1]));

  always #5 clk_in = ~clk_in;

  typedef struct { int due; bit err; logic [7:0] data; } exp_t;
  typedef struct { int det; bit b; } det_t;

  exp_t       expq[2][$];
  det_t       sched[$];
  int         cyc = 0;
  int         checks = 0, failures = 0;
  int         nbits[2] = '{0, 0};
  int         last[2] = '{0, 0};
  logic [7:0] acc[2] = '{8'h00, 8'h00};
  logic [7:0] mdata[2] = '{8'h00, 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Model: a bit lands in the cycle its synchronized edge is seen; 8 bits make a byte,
  // and a partial byte with no edge for TIMEOUT cycles since the last one is dropped.
  always @(posedge clk_in) begin : model
    int  cur;
    bit  has, b;
    cur = cyc;
    has = 1'b0;
    b   = 1'b0;
    if (!rst_n_in) begin
      sched.delete();
      for (int i = 0; i < 2; i++) begin
        nbits[i] = 0; acc[i] = 8'h00; mdata[i] = 8'h00;
      end
    end else begin
      if (sched.size() > 0 && sched[0].det == cur) begin
        has = 1'b1;
        b   = sched[0].b;
        void'(sched.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        if (has) begin
          acc[i] = {acc[i][6:0], b};
          nbits[i]++;
          last[i] = cur;
          if (nbits[i] == 8) begin
            expq[i].push_back('{cur + 1, 1'b0, acc[i]});
            mdata[i] = acc[i];
            nbits[i] = 0;
          end
        end else if (nbits[i] > 0 && cur - last[i] == ((i == 0) ? T0 : T1)) begin
          expq[i].push_back('{cur + 1, 1'b1, 8'h00});
          nbits[i] = 0;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk_in) begin : monitor
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n_in) begin
        chk($sformatf("reset_outputs%0d", i), {19'd0, dv[i], fe[i], bc[i], dout[i]}, 32'd0);
      end else begin
        if (dv[i] || fe[i]) begin
          chk($sformatf("no_dual_strobe%0d", i), {31'd0, dv[i] & fe[i]}, 32'd0);
          if (expq[i].size() == 0) begin
            chk($sformatf("unexpected_strobe%0d", i), {30'd0, dv[i], fe[i]}, 32'd0);
          end else begin
            e = expq[i].pop_front();
            chk($sformatf("strobe_kind%0d", i), {31'd0, fe[i]}, {31'd0, e.err});
            chk($sformatf("strobe_cycle%0d", i), cyc, e.due);
          end
        end
        while (expq[i].size() > 0 && expq[i][0].due < cyc) begin
          e = expq[i].pop_front();
          chk($sformatf("missed_strobe%0d_err%0d", i, e.err), 32'd0, e.due);
        end
        chk($sformatf("data_out%0d", i), {24'd0, dout[i]}, {24'd0, mdata[i]});
        chk($sformatf("bit_count%0d", i), {29'd0, bc[i]}, nbits[i]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_in); #2; end
  endtask

  task automatic send_bit(input bit b, input int half);
    spi_dat = b;
    tick(half);
    spi_clk = 1'b1;
    sched.push_back('{cyc + S, b});
    tick(half);
    spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int half);
    for (int i = 7; i >= 0; i--) send_bit(v[i], half);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] r;
    rst_n_in = 1'b0;
    tick(4);
    rst_n_in = 1'b1;
    tick(5);
    send_byte(8'hFF, 10);
    send_byte(8'hA5, 10);
    tick(30);
    send_bit(1'b1, 10); send_bit(1'b0, 10); send_bit(1'b1, 10);
    tick(1200);
    send_byte(8'h3C, 10);
    tick(30);
    // period 4 puts every edge of the 4-cycle-timeout receiver exactly on its timeout cycle
    send_byte(8'h5A, 2);
    tick(10);
    r = 8'h81;
    for (int i = 7; i >= 3; i--) send_bit(r[i], 10);
    tick(10);
    rst_n_in = 1'b0;
    tick(3);
    rst_n_in = 1'b1;
    tick(5);
    send_byte(8'h42, 10);
    tick(30);
    send_byte(8'hFF, 2);
    repeat (10) send_byte(8'($urandom), 2);
    tick(20);
    repeat (6) begin
      send_byte(8'($urandom), $urandom_range(2, 12));
      tick($urandom_range(0, 8));
    end
    send_bit(1'($urandom), 3); send_bit(1'($urandom), 3);
    tick(1100);
    for (int i = 0; i < 2; i++) chk($sformatf("queue_drained%0d", i), expq[i].size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_byte_rx.md
SPI_BYTE_RX -- requirements
Module: spi_byte_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on each raw input (legal range 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the idle clk_in cycles after which a partial byte is discarded (legal range 2..65535).
REQ-003 SHALL have port clk_in  input  1  system clock; the single clock for all logic.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port chip_data_raw  input  1  SPI data from the controller MCU, asynchronous to clk_in.
REQ-006 SHALL have port chip_clk_raw  input  1  SPI clock from the controller MCU, asynchronous to clk_in, mode 0 (idle low, sample on rising edge).
REQ-007 SHALL have port data_out  output  8  last complete received byte.
REQ-008 SHALL have port data_valid_out  output  1  one-cycle strobe marking a new data_out.
REQ-009 SHALL have port frame_error_out  output  1  one-cycle strobe marking a partial byte discarded on timeout.
REQ-010 SHALL have port bit_count_out  output  3  bits held in the current partial byte (debug).

Function
REQ-011 SHALL pass chip_clk_raw and chip_data_raw through separate SYNC_STAGES-deep flop chains of equal depth, so the data and clock stay aligned.
REQ-012 SHALL detect an SPI rising edge when the last clock-sync stage is 1 and a further registered copy of it is 0.
REQ-013 SHALL sample the last data-sync stage in the same clk_in cycle the edge is detected.
REQ-014 SHALL shift bits in MSB first: the first sampled bit of a byte becomes data_out[7].
REQ-015 SHALL implement states IDLE (bit count 0) and SHIFT (bit count 1..7).
REQ-016 SHALL move IDLE->SHIFT on an edge, and in SHIFT increment the bit count on each edge.
REQ-017 SHALL, on the 8th edge: load the assembled byte into data_out on the next clk_in edge, pulse data_valid_out high for that one cycle, and return to IDLE with bit count 0.
REQ-018 SHALL produce data_valid_out exactly 1 cycle after the cycle in which the 8th edge is detected; no other latency is permitted.
REQ-019 SHALL hold data_out stable between data_valid_out strobes; data_out changes only in a strobe cycle.
REQ-020 SHALL run a 16-bit idle counter only in SHIFT; it clears on every detected edge and on entry to SHIFT.
REQ-021 SHALL, when the idle counter reaches TIMEOUT_CYCLES-1 in SHIFT with no edge that cycle: discard the partial byte, go to IDLE, and pulse frame_error_out for one cycle; data_out is not modified.
REQ-022 SHALL give precedence to the edge when an edge and the timeout condition occur in the same cycle: the bit is accepted, the counter clears, and frame_error_out stays 0.
REQ-023 SHALL never assert data_valid_out and frame_error_out in the same cycle.
REQ-024 SHALL not saturate or wrap the idle counter while in IDLE; it holds at 0 there.
REQ-025 SHALL drive bit_count_out directly from the registered bit count.

Reset
REQ-026 SHALL, while rst_n_in=0, asynchronously force: all sync stages and the edge-history flop to 0; state IDLE; bit count 0; idle counter 0; shift register 0; data_out=8'h00; data_valid_out=0; frame_error_out=0.
REQ-027 SHALL, when reset is asserted mid-byte, discard the partial byte with no strobe of either kind.
REQ-028 SHALL ignore any raw clock edge whose synchronized rising edge is reached while reset is asserted; the first countable edge is one detected after release.

Verification
REQ-029 SHALL pass: bytes 8'hFF then 8'hA5 sent MSB first with SPI period 20 clk_in cycles -> two data_valid_out strobes with data_out 8'hFF then 8'hA5, each exactly 1 cycle after the 8th detected edge.
REQ-030 SHALL pass: 3 bits sent, then a 1200-cycle idle gap, then a full 8'h3C -> one frame_error_out pulse at idle count 999, data_out unchanged, then a strobe with 8'h3C.
REQ-031 SHALL pass: an SPI edge arriving exactly on the timeout cycle (TIMEOUT_CYCLES=4, forced) -> no frame_error_out, bit_count_out increments.
REQ-032 SHALL pass: rst_n_in pulsed low after 5 bits of 8'h81, then 8'h42 sent -> no strobe during reset, outputs reset to 0, next strobe carries 8'h42.
REQ-033 SHALL pass: the sequence 8'hFF plus 8 button bytes plus 2 joystick bytes back-to-back at SPI period 4 clk_in cycles -> 11 strobes in order with correct values and no frame_error_out.
